// File: rtl/mux_2_arbiter.sv
// mux_2_arbiter
// Round-robin arbiter that owns the select of a 2:1 mux shared by two
// requesters (A on mux input a, B on mux input b). The current owner may
// hold the mux for at most MAX_HOLD consecutive cycles while the other side
// is waiting. After that, ownership is forcibly moved and preempt pulses.
//
// Parameters
//   MAX_HOLD : max consecutive granted cycles while the other side waits (2..255)
//   CW       : hold counter width, 2**CW > MAX_HOLD
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   req_a    : requester A level request
//   req_b    : requester B level request
//   gnt_a    : A owns the mux this cycle (registered)
//   gnt_b    : B owns the mux this cycle (registered)
//   sel      : mux select, 0 = input a, 1 = input b (registered, held while idle)
//   busy     : any grant active (registered)
//   preempt  : one-cycle pulse on a hold-limit forced handover (registered)
//   hold_cnt : cycles the current owner has held the grant, 0-based
module mux_2_arbiter #(
  parameter int MAX_HOLD = 4,
  parameter int CW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_a,
  input  logic          req_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          sel,
  output logic          busy,
  output logic          preempt,
  output logic [CW-1:0] hold_cnt
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  state_t        state_q, state_d;
  logic          sel_q, sel_d;
  logic          preempt_q, preempt_d;
  logic [CW-1:0] hold_q, hold_d;
  logic          last_b_q, last_b_d;   // 1 when B was the most recent owner
  logic          gnt_a_q, gnt_b_q;

  // Owner/other view of the requests so both OWN states share one rule set.
  logic own_req, oth_req, own_is_b;

  always_comb begin
    own_is_b = (state_q == OWN_B);
    own_req  = own_is_b ? req_b : req_a;
    oth_req  = own_is_b ? req_a : req_b;

    state_d   = state_q;
    sel_d     = sel_q;
    hold_d    = hold_q;
    last_b_d  = last_b_q;
    preempt_d = 1'b0;

    case (state_q)
      IDLE: begin
        hold_d = '0;
        // A wins a tie only when B owned last; sel is left alone when idle.
        if (req_a && (!req_b || last_b_q)) begin
          state_d = OWN_A;
          sel_d   = 1'b0;
        end else if (req_b) begin
          state_d = OWN_B;
          sel_d   = 1'b1;
        end
      end

      OWN_A, OWN_B: begin
        if (!own_req) begin
          // Owner released: hand straight over if the other side waits.
          last_b_d = own_is_b;
          hold_d   = '0;
          if (oth_req) begin
            state_d = own_is_b ? OWN_A : OWN_B;
            sel_d   = ~own_is_b;
          end else begin
            state_d = IDLE;
          end
        end else if (oth_req && (hold_q == HOLD_LAST)) begin
          // Hold limit reached with a waiter: force the handover.
          last_b_d  = own_is_b;
          hold_d    = '0;
          state_d   = own_is_b ? OWN_A : OWN_B;
          sel_d     = ~own_is_b;
          preempt_d = 1'b1;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + CW'(1);
        end
        // else: saturated with no waiter, hold_cnt stays put
      end

      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      preempt_q <= 1'b0;
      hold_q    <= '0;
      last_b_q  <= 1'b1;
      gnt_a_q   <= 1'b0;
      gnt_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      preempt_q <= preempt_d;
      hold_q    <= hold_d;
      last_b_q  <= last_b_d;
      // Grants come from dedicated flops so they are glitch-free outputs.
      gnt_a_q   <= (state_d == OWN_A);
      gnt_b_q   <= (state_d == OWN_B);
    end
  end

  assign gnt_a    = gnt_a_q;
  assign gnt_b    = gnt_b_q;
  assign busy     = gnt_a_q | gnt_b_q;
  assign sel      = sel_q;
  assign preempt  = preempt_q;
  assign hold_cnt = hold_q;

endmodule

// File: tb/tb_mux_2_arbiter.sv
// Self-checking bench for mux_2_arbiter: directed phases followed by random
// request traffic, every cycle compared against a behavioural model.
module tb_mux_2_arbiter;

  localparam int MAX_HOLD = 4;
  localparam int CW       = 8;

  logic          clk;
  logic          rst;
  logic          req_a;
  logic          req_b;
  logic          gnt_a;
  logic          gnt_b;
  logic          sel;
  logic          busy;
  logic          preempt;
  logic [CW-1:0] hold_cnt;

  mux_2_arbiter #(.MAX_HOLD(MAX_HOLD), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_a    (req_a),
    .req_b    (req_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .busy     (busy),
    .preempt  (preempt),
    .hold_cnt (hold_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model: owner 0 = none, 1 = A, 2 = B.
  int m_own;
  int m_held;
  int m_last;
  bit m_sel;
  bit m_pre;
  int wait_a;
  int wait_b;

  function automatic void model_reset();
    m_own  = 0;
    m_held = 0;
    m_last = 2;
    m_sel  = 1'b0;
    m_pre  = 1'b0;
    wait_a = 0;
    wait_b = 0;
  endfunction

  function automatic void model_step(input bit ra, input bit rb);
    int nxt;
    bit mine;
    bit other;
    m_pre = 1'b0;
    nxt   = m_own;
    if (m_own == 0) begin
      if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
      else if (ra)   nxt = 1;
      else if (rb)   nxt = 2;
      else           nxt = 0;
      m_held = 0;
    end else begin
      mine  = (m_own == 1) ? ra : rb;
      other = (m_own == 1) ? rb : ra;
      if (!mine) begin
        m_last = m_own;
        nxt    = other ? 3 - m_own : 0;
        m_held = 0;
      end else if (other && m_held == MAX_HOLD - 1) begin
        m_last = m_own;
        nxt    = 3 - m_own;
        m_pre  = 1'b1;
        m_held = 0;
      end else begin
        m_held = (m_held + 1 > MAX_HOLD - 1) ? MAX_HOLD - 1 : m_held + 1;
      end
    end
    m_own = nxt;
    if (m_own != 0) m_sel = (m_own == 2);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    check({ph, ".gnt_a"},    32'(gnt_a),    32'(m_own == 1));
    check({ph, ".gnt_b"},    32'(gnt_b),    32'(m_own == 2));
    check({ph, ".sel"},      32'(sel),      32'(m_sel));
    check({ph, ".busy"},     32'(busy),     32'(m_own != 0));
    check({ph, ".preempt"},  32'(preempt),  32'(m_pre));
    check({ph, ".hold_cnt"}, 32'(hold_cnt), 32'(m_held));
    check({ph, ".mutex"},    32'(gnt_a & gnt_b), 32'd0);
  endtask

  task automatic step(input string ph, input bit ra, input bit rb);
    req_a = ra;
    req_b = rb;
    @(posedge clk);
    #1;
    model_step(ra, rb);
    check_all(ph);
    wait_a = (ra && !gnt_a) ? wait_a + 1 : 0;
    wait_b = (rb && !gnt_b) ? wait_b + 1 : 0;
    check({ph, ".starve_a"}, 32'(wait_a <= MAX_HOLD + 1), 32'd1);
    check({ph, ".starve_b"}, 32'(wait_b <= MAX_HOLD + 1), 32'd1);
  endtask

  initial begin
    bit ra;
    bit rb;
    rst   = 1'b1;
    req_a = 1'b0;
    req_b = 1'b0;
    model_reset();

    // Reset state with clock running.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single requester B: hold_cnt climbs then saturates, no preempt.
    for (int i = 0; i < 10; i++) step("single_b", 1'b0, 1'b1);

    // Asynchronous reset mid-grant: outputs clear before any clock edge.
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    rst = 1'b0;

    // After reset A wins the first tie.
    step("rst_tie", 1'b1, 1'b1);
    check("rst_tie.gnt_a_direct", 32'(gnt_a), 32'd1);

    // Sustained contention: 4-cycle slices with preempt pulses.
    for (int i = 0; i < 20; i++) step("contend", 1'b1, 1'b1);

    // Handover OWN_A -> OWN_B with no idle bubble.
    step("to_idle", 1'b0, 1'b0);
    step("own_a", 1'b1, 1'b0);
    step("own_a", 1'b1, 1'b0);
    step("handover", 1'b0, 1'b1);
    check("handover.busy_direct", 32'(busy), 32'd1);

    // Release to idle keeps sel at 1, then A wins the tie.
    step("release", 1'b0, 1'b0);
    check("release.sel_direct", 32'(sel), 32'd1);
    step("tie_after_b", 1'b1, 1'b1);

    // Random traffic with sticky requests.
    ra = 1'b0;
    rb = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) ra = ~ra;
      if ($urandom_range(0, 3) == 0) rb = ~rb;
      step("random", ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_2_arbiter.md
Name: mux_2_arbiter

Overview:
Round-robin arbiter that shares the 2:1 mux datapath between two requesters (A on mux input a, B on mux input b). It drives the mux select and per-requester grants, and enforces a bounded hold time so neither requester can starve the other. It sits directly upstream of the mux select input and is clocked in the same domain.

Parameters:
MAX_HOLD, 4, max consecutive granted cycles while the other requester waits; legal range 2..255
CW, 8, width of hold counter; must satisfy 2^CW > MAX_HOLD

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
req_a  input  1  requester A wants the mux (level, held until done)
req_b  input  1  requester B wants the mux (level, held until done)
gnt_a  output  1  A owns the mux this cycle (registered)
gnt_b  output  1  B owns the mux this cycle (registered)
sel  output  1  mux select: 0 = input a, 1 = input b (registered)
busy  output  1  1 while any grant is active
preempt  output  1  one-cycle pulse when a grant is forcibly moved by MAX_HOLD expiry
hold_cnt  output  CW  cycles the current owner has held the grant, 0-based

Behaviour:
- One clock; reset is asynchronous and active-high; ports named clk and rst.
- Reset (asserted at any time, including mid-grant): state IDLE, gnt_a=0, gnt_b=0, sel=0, busy=0, preempt=0, hold_cnt=0, last_owner=B (so A wins the first tie). Takes effect immediately, not at next edge.
- All outputs registered; grant appears 1 cycle after request is sampled high. gnt_a and gnt_b never both 1.
- States: IDLE, OWN_A, OWN_B.
- IDLE: req_a&req_b -> grant the requester not equal to last_owner; only req_a -> OWN_A; only req_b -> OWN_B; none -> stay. On entry to OWN_x: gnt_x=1, sel updated (A->0, B->1), hold_cnt=0.
- OWN_A (OWN_B symmetric):
  - req_a=0 & req_b=1 -> OWN_B next cycle (direct handover, no IDLE bubble), hold_cnt=0, preempt=0.
  - req_a=0 & req_b=0 -> IDLE, gnts=0, hold_cnt=0.
  - req_a=1 & req_b=0 -> stay; hold_cnt saturates at MAX_HOLD-1 (no wrap, no preemption without a waiter).
  - req_a=1 & req_b=1 & hold_cnt<MAX_HOLD-1 -> stay, hold_cnt+1.
  - req_a=1 & req_b=1 & hold_cnt==MAX_HOLD-1 -> OWN_B, preempt=1 for that one cycle, hold_cnt=0. A must re-win via round-robin.
- last_owner updates on every transition out of OWN_x to x.
- sel retains its last value in IDLE (no mux toggling while idle).
- busy = gnt_a | gnt_b.
- Requests dropped and re-raised in the same cycle are not visible; a request is the sampled level only.

Test Plan:
- Reset: assert rst mid-cycle while gnt_b=1 -> gnt_b, sel, busy, hold_cnt drop to 0 without waiting for clk edge; after release with req_a=req_b=1, gnt_a=1 sel=0 one cycle later.
- Single requester: req_b=1 for 10 cycles, req_a=0 -> gnt_b=1 sel=1 from cycle 1, hold_cnt climbs 0,1,2,3 then stays 3, preempt never asserts.
- Contention, MAX_HOLD=4: req_a=req_b=1 continuously -> gnt_a for 4 cycles, preempt pulse, gnt_b for 4 cycles, preempt pulse, repeating; sel toggles 0/1 every 4 cycles.
- Handover: OWN_A, req_a falls while req_b=1 -> next cycle gnt_b=1 sel=1 hold_cnt=0 preempt=0, no cycle with busy=0.
- Release to idle: OWN_B, req_b falls, req_a=0 -> gnt_b=0 busy=0, sel stays 1; then req_a=req_b=1 together -> gnt_a wins (last_owner=B).
- Mutual exclusion check: random req_a/req_b for 1000 cycles -> gnt_a&gnt_b never 1, no requester waits more than MAX_HOLD+1 cycles.
